// File: rtl/wishbone_arbiter_2.sv
// Two-master Wishbone arbiter: one registered grant per locked bus cycle, round-robin
// or fixed-priority tie-break, and a watchdog that ends stalled slave cycles with err.
module wishbone_arbiter_2 #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ROUND_ROBIN  = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,

    output logic [1:0]              gnt_o,
    output logic                    timeout_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0] gnt;
    logic [1:0] gnt_next;
    logic       last;
    logic       to_err;
    logic       term;

    assign term = wbs_ack_i | wbs_err_i | wbs_rty_i;

    // Grant decision: a holder keeps the bus while its cyc stays high
    always_comb begin
        gnt_next = 2'b00;
        if (gnt[0] && wbm0_cyc_i) begin
            gnt_next = 2'b01;
        end else if (gnt[1] && wbm1_cyc_i) begin
            gnt_next = 2'b10;
        end else if (wbm0_cyc_i && wbm1_cyc_i) begin
            gnt_next = ((ROUND_ROBIN != 0) && !last) ? 2'b10 : 2'b01;
        end else if (wbm0_cyc_i) begin
            gnt_next = 2'b01;
        end else if (wbm1_cyc_i) begin
            gnt_next = 2'b10;
        end
    end

    // last resets to master 1 so the first tie out of reset goes to master 0
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt  <= 2'b00;
            last <= 1'b1;
        end else begin
            gnt <= gnt_next;
            if (gnt_next != 2'b00) begin
                last <= gnt_next[1];
            end
        end
    end

    // Request mux toward the shared slave
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_stb_o = 1'b0;
        wbs_cyc_o = 1'b0;
        if (gnt[0]) begin
            wbs_adr_o = wbm0_adr_i;
            wbs_dat_o = wbm0_dat_i;
            wbs_we_o  = wbm0_we_i;
            wbs_sel_o = wbm0_sel_i;
            wbs_stb_o = wbm0_stb_i & ~to_err;
            wbs_cyc_o = wbm0_cyc_i;
        end else if (gnt[1]) begin
            wbs_adr_o = wbm1_adr_i;
            wbs_dat_o = wbm1_dat_i;
            wbs_we_o  = wbm1_we_i;
            wbs_sel_o = wbm1_sel_i;
            wbs_stb_o = wbm1_stb_i & ~to_err;
            wbs_cyc_o = wbm1_cyc_i;
        end
    end

    // Responses are combinational so single-cycle slaves keep full throughput
    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;
    assign wbm0_ack_o = wbs_ack_i & gnt[0];
    assign wbm1_ack_o = wbs_ack_i & gnt[1];
    assign wbm0_rty_o = wbs_rty_i & gnt[0];
    assign wbm1_rty_o = wbs_rty_i & gnt[1];
    assign wbm0_err_o = (wbs_err_i | to_err) & gnt[0];
    assign wbm1_err_o = (wbs_err_i | to_err) & gnt[1];

    assign gnt_o     = gnt;
    assign timeout_o = to_err;

    if (TIMEOUT > 0) begin : g_wd
        logic [CNT_W-1:0] wd_cnt;
        logic             wd_clear;
        logic             wd_fire;

        always_comb begin
            wd_clear = term | ~wbs_stb_o | (gnt_next != gnt) | to_err;
            wd_fire  = ~wd_clear & wbs_cyc_o & (wd_cnt == CNT_W'(TIMEOUT - 1));
        end

        // to_err is a single-cycle pulse; the counter restarts from zero behind it
        always_ff @(posedge clk) begin
            if (rst) begin
                wd_cnt <= '0;
                to_err <= 1'b0;
            end else begin
                to_err <= wd_fire;
                if (wd_clear || wd_fire) begin
                    wd_cnt <= '0;
                end else if (wbs_cyc_o) begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                end
            end
        end
    end else begin : g_no_wd
        assign to_err = 1'b0;
    end

endmodule

// File: doc/wishbone_arbiter_2.md
# wishbone_arbiter_2

Two-master Wishbone arbiter that shares one downstream Wishbone bus, normally the master port of `wishbone_mux`, between two requesters such as the SPI bridge and the DMA engine. It registers a grant per bus cycle and holds it for the whole `cyc` assertion (locked transfers). Contention is resolved round-robin or by fixed priority. A watchdog terminates slave cycles that never complete, using an error response.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width in bits (8/16/32/64)
- `ADDR_WIDTH`, 32, address width in bits
- `SELECT_WIDTH`, `DATA_WIDTH/8`, byte-select width
- `ROUND_ROBIN`, 1, 1 = round-robin on contention, 0 = master 0 always wins
- `TIMEOUT`, 255, cycles of unanswered `stb` before forced error; 0 disables the watchdog; counter width is `$clog2(TIMEOUT+1)`

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `wbm0_adr_i`, `wbm0_dat_i`, `wbm0_we_i`, `wbm0_sel_i`, `wbm0_stb_i`, `wbm0_cyc_i`  in  per-parameter widths  master 0 request
- `wbm0_dat_o`  out  DATA_WIDTH  master 0 read data
- `wbm0_ack_o`, `wbm0_err_o`, `wbm0_rty_o`  out  1  master 0 termination
- `wbm1_*`  same set and directions as `wbm0_*`  master 1
- `wbs_adr_o`, `wbs_dat_o`, `wbs_we_o`, `wbs_sel_o`, `wbs_stb_o`, `wbs_cyc_o`  out  per-parameter widths  shared slave request
- `wbs_dat_i`  in  DATA_WIDTH  slave read data
- `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i`  in  1  slave termination
- `gnt_o`  out  2  one-hot registered grant; `00` = bus idle
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires

## Operation
- State:
  - `gnt` [1:0] one-hot or zero.
  - `last` (index of the most recently granted master).
  - Watchdog counter `wd_cnt`.
  - `to_err` flag.
- Grant update, every edge:
  - If the granted master's `cyc_i` is high, keep the grant.
  - Else grant the requesting master (`cyc_i` high) if only one requests.
  - If both request: with `ROUND_ROBIN`=1, grant master `~last`; with 0, grant master 0.
  - If none requests: `gnt`=00.
  - On every new grant, `last` is set to the granted index.
- Request path: the slave outputs take the granted master's `adr`/`dat`/`we`/`sel`. `wbs_cyc_o`=granted `cyc_i`; `wbs_stb_o`=granted `stb_i & ~to_err`. With no grant, all slave outputs are 0.
- Response path:
  - `wbs_dat_i` is broadcast to both `wbmN_dat_o`.
  - `wbmN_ack_o`=`wbs_ack_i & gnt[N]`; `wbmN_rty_o` likewise.
  - `wbmN_err_o`=`(wbs_err_i | to_err) & gnt[N]`.
  - An ungranted master never sees any termination.
- Watchdog (`TIMEOUT`>0):
  - `wd_cnt` clears on any of: `wbs_ack_i|err_i|rty_i`, `wbs_stb_o` low, grant change, or `to_err`.
  - Otherwise it increments while `wbs_cyc_o & wbs_stb_o`.
  - When `wd_cnt`==`TIMEOUT-1` and no termination arrives this cycle, set `to_err` and `timeout_o` for exactly one cycle.
  - `TIMEOUT`=0: `to_err` and `timeout_o` are tied 0.
- Reset values:
  - `gnt`=00; `last`=1, so the first tie goes to master 0.
  - `wd_cnt`=0, `to_err`=0, `timeout_o`=0.
  - All slave request outputs and all master termination outputs are 0.
  - `wbmN_dat_o` follows `wbs_dat_i`.

## Timing
- Grant latency: 1 cycle.
  - A master raising `cyc`+`stb` at edge N is granted at N+1.
  - `wbs_cyc_o`/`wbs_stb_o` assert combinationally in the cycle after edge N+1.
- Handover: when the holder drops `cyc` before edge M, a waiting master is granted at edge M with no idle cycle. Slave `cyc` is low for at least the cycle before M, as the holder dropped it.
- Termination paths (`ack`/`err`/`rty`) are combinational: zero added latency, so single-cycle slaves keep full throughput.
- A grant is never revoked while its `cyc` is high, even under contention or after a watchdog error. The master must drop `cyc` itself.
- `rst` mid-transfer: all outputs are at reset values the cycle after the reset edge, and the in-flight transfer is abandoned.
- `to_err` cycle: `wbs_stb_o` is forced low, so a late slave `ack` in that cycle is still forwarded. Both `ack` and `err` may then be seen together, and `err` wins at the master side by convention.

## Test plan
- Single master: m0 reads address `0x10`, slave acks after 2 wait states with `0xDEADBEEF` -> `gnt_o`=01 one cycle after request; m0 gets `ack` and `0xDEADBEEF`; `wbm1_ack_o` stays 0.
- Simultaneous request out of reset, `ROUND_ROBIN`=1 -> m0 granted first. Then m1 is granted on the edge m0 drops `cyc`, then m0 again; the grant sequence is 01,10,01 with no idle cycle.
- `ROUND_ROBIN`=0, both masters requesting continuously with 1-cycle transfers -> m0 holds every grant; m1 is starved and gets the bus only when m0's `cyc` drops.
- Locked cycle: m0 keeps `cyc` high across 3 `stb` pulses while m1 requests -> `gnt_o` stays 01 throughout; m1 is granted the edge after m0's `cyc` falls.
- Watchdog with `TIMEOUT`=4, slave never acks -> `timeout_o` and `wbm0_err_o` pulse exactly 4 cycles after the first slave `stb`; `wbs_stb_o` is low in that cycle; `wd_cnt` is 0 afterwards.
- Reset asserted mid-transfer with m1 granted -> next cycle `gnt_o`=00, `wbs_cyc_o`=0, `timeout_o`=0. After release, a tie grants m0.
